// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered MIPS ALU control stage. Decodes opcode/funct into an
// ALU op code, sequences multi-cycle mult/div and counts illegal beats.
module alu_ctrl_seq #(
    parameter int OPW        = 6,
    parameter int FNW        = 6,
    parameter int ALUW       = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8,
    parameter int CNTW       = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  opcode,
    input  logic [FNW-1:0]  funct,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ALUW-1:0] alu_op,
    output logic            illegal,
    output logic            hilo_we,
    output logic            mdu_start,
    output logic            busy,
    output logic [CNTW-1:0] illegal_count
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // out_valid never depends on out_ready; in_ready may depend on out_ready.
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        MDU  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ALUW-1:0] alu_op_q, alu_op_d;
    logic            illegal_q, illegal_d;
    logic            hilo_we_q, hilo_we_d;
    logic            mdu_start_q, mdu_start_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      mdu_op_q, mdu_op_d;
    logic [CNTW-1:0] illegal_count_q, illegal_count_d;

    logic [5:0] op6;
    logic [5:0] fn6;
    logic       op_hi_zero;
    logic       fn_hi_zero;
    logic [3:0] dec_code;
    logic       dec_illegal;
    logic       dec_mdu;
    logic       dec_div;
    logic       accept;
    logic       consume;

    assign op6        = opcode[5:0];
    assign fn6        = funct[5:0];
    assign op_hi_zero = ((opcode >> 6) == '0);
    assign fn_hi_zero = ((funct >> 6) == '0);

    // Undecodable encodings fall through with code 0010 and the illegal flag set.
    always_comb begin
        dec_code    = 4'b0010;
        dec_illegal = 1'b1;
        dec_mdu     = 1'b0;
        dec_div     = 1'b0;
        if (op_hi_zero) begin
            case (op6)
                6'b000000: begin
                    if (fn_hi_zero) begin
                        dec_illegal = 1'b0;
                        case (fn6)
                            6'b100000: dec_code = 4'b0010;
                            6'b100010: dec_code = 4'b1101;
                            6'b000000: dec_code = 4'b0100;
                            6'b100100: dec_code = 4'b0000;
                            6'b100101: dec_code = 4'b1110;
                            6'b100111: dec_code = 4'b1100;
                            6'b101010: dec_code = 4'b0111;
                            6'b001000: dec_code = 4'b1111;
                            6'b011000: begin
                                dec_code = 4'b0101;
                                dec_mdu  = 1'b1;
                            end
                            6'b011010: begin
                                dec_code = 4'b0110;
                                dec_mdu  = 1'b1;
                                dec_div  = 1'b1;
                            end
                            default: dec_illegal = 1'b1;
                        endcase
                    end
                end
                6'b100011: begin dec_code = 4'b1000; dec_illegal = 1'b0; end
                6'b101011: begin dec_code = 4'b1001; dec_illegal = 1'b0; end
                6'b001000: begin dec_code = 4'b0011; dec_illegal = 1'b0; end
                6'b001100: begin dec_code = 4'b0001; dec_illegal = 1'b0; end
                6'b000100: begin dec_code = 4'b1010; dec_illegal = 1'b0; end
                6'b000011: begin dec_code = 4'b1011; dec_illegal = 1'b0; end
                default:   dec_illegal = 1'b1;
            endcase
        end
    end

    assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign consume   = (state_q == HOLD) && out_ready;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == MDU);
    assign alu_op    = alu_op_q;
    assign illegal   = illegal_q;
    assign hilo_we   = hilo_we_q;
    assign mdu_start = mdu_start_q;
    assign illegal_count = illegal_count_q;

    always_comb begin
        state_d         = state_q;
        alu_op_d        = alu_op_q;
        illegal_d       = illegal_q;
        hilo_we_d       = hilo_we_q;
        mdu_start_d     = 1'b0;
        cnt_d           = cnt_q;
        mdu_op_d        = mdu_op_q;
        illegal_count_d = illegal_count_q;

        if (consume && illegal_q && (illegal_count_q != '1)) begin
            illegal_count_d = illegal_count_q + CNTW'(1);
        end

        case (state_q)
            IDLE: ;
            HOLD: begin
                if (out_ready) begin
                    state_d   = IDLE;
                    hilo_we_d = 1'b0;
                end
            end
            MDU: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d   = HOLD;
                    alu_op_d  = ALUW'(mdu_op_q);
                    illegal_d = 1'b0;
                    hilo_we_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept is only possible from IDLE or a consuming HOLD, so it overrides.
        if (accept) begin
            hilo_we_d = 1'b0;
            if (dec_mdu) begin
                state_d     = MDU;
                mdu_start_d = 1'b1;
                mdu_op_d    = dec_code;
                cnt_d       = dec_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
            end else begin
                state_d   = HOLD;
                alu_op_d  = ALUW'(dec_code);
                illegal_d = dec_illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            alu_op_q        <= '0;
            illegal_q       <= 1'b0;
            hilo_we_q       <= 1'b0;
            mdu_start_q     <= 1'b0;
            cnt_q           <= '0;
            mdu_op_q        <= '0;
            illegal_count_q <= '0;
        end else begin
            state_q         <= state_d;
            alu_op_q        <= alu_op_d;
            illegal_q       <= illegal_d;
            hilo_we_q       <= hilo_we_d;
            mdu_start_q     <= mdu_start_d;
            cnt_q           <= cnt_d;
            mdu_op_q        <= mdu_op_d;
            illegal_count_q <= illegal_count_d;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: table-driven vectors, directed multi-cycle sequences and a
// randomized run against a transaction-level reference model.
module tb_alu_ctrl_seq;

  localparam int MUL_CYC = 4;
  localparam int DIV_CYC = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;

  logic       in_ready, out_valid, illegal, hilo_we, mdu_start, busy;
  logic [3:0] alu_op;
  logic [7:0] illegal_count;

  logic       in_ready6, out_valid6, illegal6, hilo_we6, mdu_start6, busy6;
  logic [5:0] alu_op6;
  logic [7:0] illegal_count6;

  alu_ctrl_seq #(
    .OPW(6), .FNW(6), .ALUW(4), .MUL_CYCLES(MUL_CYC), .DIV_CYCLES(DIV_CYC), .CNTW(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .illegal(illegal), .hilo_we(hilo_we), .mdu_start(mdu_start),
    .busy(busy), .illegal_count(illegal_count)
  );

  alu_ctrl_seq #(
    .OPW(6), .FNW(6), .ALUW(6), .MUL_CYCLES(MUL_CYC), .DIV_CYCLES(DIV_CYC), .CNTW(8)
  ) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
    .opcode(opcode), .funct(funct), .out_valid(out_valid6), .out_ready(out_ready),
    .alu_op(alu_op6), .illegal(illegal6), .hilo_we(hilo_we6), .mdu_start(mdu_start6),
    .busy(busy6), .illegal_count(illegal_count6)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn, input logic ordy);
    in_valid = v;
    opcode = op;
    funct = fn;
    out_ready = ordy;
  endtask

  task automatic drain();
    drive(1'b0, 6'd0, 6'd0, 1'b1);
    repeat (DIV_CYC + 2) tick();
  endtask

  // reference decode straight from the instruction table
  typedef struct {
    logic [3:0] code;
    logic       ill;
    int         lat;
  } dec_t;

  function automatic dec_t ref_decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t r;
    r.code = 4'b0010;
    r.ill = 1'b0;
    r.lat = 0;
    if (op == 6'b000000) begin
      case (fn)
        6'b100000: r.code = 4'b0010;
        6'b100010: r.code = 4'b1101;
        6'b000000: r.code = 4'b0100;
        6'b100100: r.code = 4'b0000;
        6'b100101: r.code = 4'b1110;
        6'b100111: r.code = 4'b1100;
        6'b101010: r.code = 4'b0111;
        6'b001000: r.code = 4'b1111;
        6'b011000: begin r.code = 4'b0101; r.lat = MUL_CYC; end
        6'b011010: begin r.code = 4'b0110; r.lat = DIV_CYC; end
        default:   r.ill = 1'b1;
      endcase
    end else begin
      case (op)
        6'b100011: r.code = 4'b1000;
        6'b101011: r.code = 4'b1001;
        6'b001000: r.code = 4'b0011;
        6'b001100: r.code = 4'b0001;
        6'b000100: r.code = 4'b1010;
        6'b000011: r.code = 4'b1011;
        default:   r.ill = 1'b1;
      endcase
    end
    return r;
  endfunction

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  vec_t vecs[18];

  localparam int NPOOL = 19;
  logic [5:0] pool_op[NPOOL];
  logic [5:0] pool_fn[NPOOL];

  // scoreboard: {hilo_we, illegal, code}
  logic [5:0] exp_q[$];
  logic [5:0] beat;
  bit         m_full, m_mdu, m_start, m_rdy;
  int         m_cnt, m_done, cyc, exp_cnt, k;
  dec_t       d;

  initial begin
    vecs[0]  = '{6'b000000, 6'b100000, 4'b0010, 1'b0};
    vecs[1]  = '{6'b100011, 6'b010101, 4'b1000, 1'b0};
    vecs[2]  = '{6'b101011, 6'b000000, 4'b1001, 1'b0};
    vecs[3]  = '{6'b000100, 6'b111111, 4'b1010, 1'b0};
    vecs[4]  = '{6'b000000, 6'b100010, 4'b1101, 1'b0};
    vecs[5]  = '{6'b000000, 6'b000000, 4'b0100, 1'b0};
    vecs[6]  = '{6'b000000, 6'b100100, 4'b0000, 1'b0};
    vecs[7]  = '{6'b111111, 6'b100000, 4'b0010, 1'b1};
    vecs[8]  = '{6'b000000, 6'b100101, 4'b1110, 1'b0};
    vecs[9]  = '{6'b000000, 6'b100111, 4'b1100, 1'b0};
    vecs[10] = '{6'b000000, 6'b101010, 4'b0111, 1'b0};
    vecs[11] = '{6'b000000, 6'b001000, 4'b1111, 1'b0};
    vecs[12] = '{6'b000000, 6'b000001, 4'b0010, 1'b1};
    vecs[13] = '{6'b001000, 6'b011000, 4'b0011, 1'b0};
    vecs[14] = '{6'b001100, 6'b000011, 4'b0001, 1'b0};
    vecs[15] = '{6'b000011, 6'b101010, 4'b1011, 1'b0};
    vecs[16] = '{6'b000010, 6'b000000, 4'b0010, 1'b1};
    vecs[17] = '{6'b100011, 6'b000000, 4'b1000, 1'b0};

    for (int i = 0; i < 16; i++) begin
      pool_op[i] = (vecs[i].op == 6'b111111) ? 6'b000000 : vecs[i].op;
      pool_fn[i] = (vecs[i].op == 6'b111111) ? 6'b011000 : vecs[i].fn;
    end
    pool_op[16] = 6'b000000; pool_fn[16] = 6'b011010;
    pool_op[17] = 6'b111111; pool_fn[17] = 6'b000000;
    pool_op[18] = 6'b000000; pool_fn[18] = 6'b011000;

    // reset
    drive(1'b0, 6'd0, 6'd0, 1'b1);
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_op6", alu_op6, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_hilo_we", hilo_we, 0);
    chk("rst_mdu_start", mdu_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_illegal_count", illegal_count, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // table-driven back-to-back stream
    exp_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].fn, 1'b1);
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_alu_op", i), alu_op, vecs[i].code);
      chk($sformatf("vec%0d_illegal", i), illegal, vecs[i].ill);
      chk($sformatf("vec%0d_alu_op6", i), alu_op6, {2'b00, vecs[i].code});
      chk($sformatf("vec%0d_count", i), illegal_count, exp_cnt);
      if (vecs[i].ill) exp_cnt++;
    end
    drive(1'b0, 6'd0, 6'd0, 1'b1);
    tick();
    chk("vec_end_count", illegal_count, exp_cnt);
    chk("vec_end_out_valid", out_valid, 0);

    // backpressure: slt held three cycles, then or with no bubble
    drain();
    drive(1'b1, 6'b000000, 6'b101010, 1'b0);
    #1;
    chk("stall_idle_in_ready", in_ready, 1);
    tick();
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 6'b100011, 6'($urandom), 1'b0);
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_alu_op", alu_op, 4'b0111);
      chk("stall_out_valid", out_valid, 1);
      tick();
    end
    drive(1'b1, 6'b000000, 6'b100101, 1'b1);
    #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_alu_op_old", alu_op, 4'b0111);
    tick();
    chk("release_alu_op_new", alu_op, 4'b1110);
    chk("release_out_valid", out_valid, 1);

    // mult timing
    drain();
    drive(1'b1, 6'b000000, 6'b011000, 1'b1);
    tick();
    for (int kk = 1; kk <= MUL_CYC; kk++) begin
      drive(kk < MUL_CYC, 6'b100011, 6'd0, 1'b1);
      #1;
      chk($sformatf("mult_c%0d_mdu_start", kk), mdu_start, kk == 1);
      chk($sformatf("mult_c%0d_busy", kk), busy, kk < MUL_CYC);
      chk($sformatf("mult_c%0d_out_valid", kk), out_valid, kk == MUL_CYC);
      chk($sformatf("mult_c%0d_hilo_we", kk), hilo_we, kk == MUL_CYC);
      chk($sformatf("mult_c%0d_in_ready", kk), in_ready, kk == MUL_CYC);
      if (kk == MUL_CYC) chk("mult_alu_op", alu_op, 4'b0101);
      tick();
    end
    chk("mult_after_out_valid", out_valid, 0);
    chk("mult_after_hilo_we", hilo_we, 0);

    // illegal counter saturation
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 6'b111111, 6'($urandom), 1'b1);
      tick();
      chk("sat_illegal", illegal, 1);
      chk("sat_alu_op", alu_op, 4'b0010);
      chk("sat_count", illegal_count, (i > 255) ? 255 : i);
    end
    drive(1'b0, 6'd0, 6'd0, 1'b1);
    tick();
    chk("sat_final_count", illegal_count, 255);
    chk("sat_final_out_valid", out_valid, 0);

    // div aborted by reset in its second MDU cycle
    drive(1'b1, 6'b000000, 6'b011010, 1'b1);
    #1;
    chk("div_in_ready", in_ready, 1);
    tick();
    chk("div_c1_busy", busy, 1);
    chk("div_c1_mdu_start", mdu_start, 1);
    drive(1'b0, 6'd0, 6'd0, 1'b1);
    tick();
    chk("div_c2_busy", busy, 1);
    chk("div_c2_mdu_start", mdu_start, 0);
    rst_n = 1'b0;
    #1;
    chk("div_rst_in_ready", in_ready, 0);
    tick();
    chk("div_rst_busy", busy, 0);
    chk("div_rst_out_valid", out_valid, 0);
    chk("div_rst_alu_op", alu_op, 0);
    chk("div_rst_illegal", illegal, 0);
    chk("div_rst_hilo_we", hilo_we, 0);
    chk("div_rst_mdu_start", mdu_start, 0);
    chk("div_rst_count", illegal_count, 0);
    rst_n = 1'b1;
    #1;
    chk("div_rel_in_ready", in_ready, 1);
    for (int i = 0; i < DIV_CYC + 2; i++) begin
      tick();
      chk("div_abort_out_valid", out_valid, 0);
      chk("div_abort_busy", busy, 0);
    end

    // randomized run against the reference model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_full = 0; m_mdu = 0; m_start = 0; m_cnt = 0; m_done = 0; cyc = 0;
    exp_q.delete();
    for (int i = 0; i < 800; i++) begin
      k = $urandom_range(0, NPOOL - 1);
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      opcode = pool_op[k];
      funct = (pool_op[k] != 6'b000000) ? 6'($urandom) : pool_fn[k];
      #1;
      m_rdy = !m_mdu && (!m_full || out_ready);
      chk("rnd_in_ready", in_ready, m_rdy);
      chk("rnd_out_valid", out_valid, m_full);
      chk("rnd_busy", busy, m_mdu);
      chk("rnd_mdu_start", mdu_start, m_start);
      chk("rnd_count", illegal_count, m_cnt);
      if (m_full) begin
        beat = exp_q[0];
        chk("rnd_alu_op", alu_op, beat[3:0]);
        chk("rnd_illegal", illegal, beat[4]);
        chk("rnd_hilo_we", hilo_we, beat[5]);
      end else begin
        chk("rnd_hilo_idle", hilo_we, 0);
      end
      d = ref_decode(opcode, funct);
      if (m_full && out_ready) begin
        if (exp_q[0][4] && m_cnt < 255) m_cnt++;
        void'(exp_q.pop_front());
        m_full = 0;
      end
      m_start = 0;
      if (m_mdu && (cyc + 1 == m_done)) begin
        m_mdu = 0;
        m_full = 1;
      end
      if (in_valid && m_rdy) begin
        exp_q.push_back({d.lat != 0, d.ill, d.code});
        if (d.lat != 0) begin
          m_mdu = 1;
          m_start = 1;
          m_done = cyc + d.lat;
        end else begin
          m_full = 1;
        end
      end
      cyc++;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
